mdu_multicycle: RTL and testbench

MDU_MULTICYCLE -- requirements
Module: mdu_multicycle

---
 rtl/mdu_multicycle.sv | 154 +++++++++++++++
 tb/tb_mdu_multicycle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_multicycle.sv
// rtl/mdu_multicycle.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional accumulate ops (madd/maddu/msub/msubu) enabled by macro MDU_MADD_EN.
module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [CW-1:0]    count;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic is_mul;
  logic is_div;
  logic accept;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    accept = start && !busy && !flush && (is_mul || is_div);
  end

  assign busy = (count != '0);

  // Products are formed at full 2*WIDTH so signed/unsigned results fall out of truncation.
  logic [2*WIDTH-1:0]        ua, ub, prod_u;
  logic signed [2*WIDTH-1:0] sa, sb, prod_s;

  always_comb begin
    ua     = {{WIDTH{1'b0}}, a_q};
    ub     = {{WIDTH{1'b0}}, b_q};
    sa     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    sb     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = ua * ub;
    prod_s = sa * sb;
  end

  // Zero divisor is replaced by 1 so the datapath never sees x; the result is discarded anyway.
  logic [WIDTH-1:0]        div_b;
  logic signed [WIDTH-1:0] sdvd, sdvs;
  logic [WIDTH-1:0]        q_u, r_u, q_s, r_s;
  logic                    div_zero;
  logic                    min_neg1;

  always_comb begin
    div_zero = (b_q == '0);
    div_b    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    min_neg1 = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}});
    sdvd     = a_q;
    sdvs     = div_b;
    q_u      = a_q / div_b;
    r_u      = a_q % div_b;
    if (min_neg1) begin
      q_s = a_q;
      r_s = '0;
    end else begin
      q_s = sdvd / sdvs;
      r_s = sdvd % sdvs;
    end
  end

  logic [2*WIDTH-1:0] result;
  logic               update;

  always_comb begin
    result = {hi, lo};
    update = 1'b1;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        result = {r_s, q_s};
        update = !div_zero;
      end
      OP_DIVU: begin
        result = {r_u, q_u};
        update = !div_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default: update = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (flush) begin
          count <= '0;
        end else begin
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            done <= 1'b1;
            if (update) {hi, lo} <= result;
          end
        end
      end else if (accept) begin
        count <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
      end else if (start && !flush && (op == OP_MTHI)) begin
        hi <= a;
      end else if (start && !flush && (op == OP_MTLO)) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// tb/tb_mdu_multicycle.sv - directed self-checking bench for mdu_multicycle
// Accumulate checks follow MDU_MADD_EN when the bench is built with it.
module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_multicycle #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bc, output int dc);
    bc = 0;
    dc = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int bc, dc;
    run_op(4'd1, 32'hFFFFFFFD, 32'd7, bc, dc);
    n_tests++; if (bc != 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", bc); end
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL mult_done_cycles got %0d want 1", dc); end
    n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_tests++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, bc, dc);
    n_tests++; if (hi !== 32'h1) begin n_fail++; $display("FAIL multu_hi got %h want 00000001", hi); end
    n_tests++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    int bc, dc;
    run_op(4'd4, 32'd100, 32'd7, bc, dc);
    n_tests++; if (bc != 10) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 10", bc); end
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL divu_done_cycles got %0d want 1", dc); end
    n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h want 00000002", hi); end
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, bc, dc);
    n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    n_tests++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_min_lo got %h want 80000000", lo); end
    n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_min_hi got %h want 0", hi); end
  endtask

  task automatic test_div_zero;
    int bc, dc;
    write_reg(4'd5, 32'h55);
    n_tests++; if (hi !== 32'h55) begin n_fail++; $display("FAIL mthi_hi got %h want 00000055", hi); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_busy_done got %0b%0b want 00", busy, done); end
    write_reg(4'd6, 32'hAA);
    n_tests++; if (lo !== 32'hAA) begin n_fail++; $display("FAIL mtlo_lo got %h want 000000aa", lo); end
    bc = 0;
    dc = 0;
    @(negedge clk);
    start = 1'b1; op = 4'd3; a = 32'd123; b = 32'd0;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (i == 2) begin start = 1'b1; op = 4'd6; a = 32'h77; end
      else if (i == 3) begin start = 1'b0; op = 4'd0; end
      @(negedge clk);
    end
    n_tests++; if (bc != 10) begin n_fail++; $display("FAIL div0_busy_cycles got %0d want 10", bc); end
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL div0_done_cycles got %0d want 1", dc); end
    n_tests++; if (hi !== 32'h55) begin n_fail++; $display("FAIL div0_hi got %h want 00000055", hi); end
    n_tests++; if (lo !== 32'hAA) begin n_fail++; $display("FAIL div0_lo got %h want 000000aa (mtlo while busy must be ignored)", lo); end
  endtask

  task automatic test_flush;
    int dc;
    write_reg(4'd5, 32'h11);
    write_reg(4'd6, 32'h22);
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %0b want 0", busy); end
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    n_tests++; if (dc != 0) begin n_fail++; $display("FAIL flush_done got %0d want 0", dc); end
    n_tests++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL flush_hilo got %h/%h want 00000011/00000022", hi, lo); end
    start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0; flush = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_block_busy got %0b want 0", busy); end
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_last_busy_done got %0b%0b want 00", busy, done); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_last_done_late got %0b want 0", done); end
    n_tests++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL flush_last_hilo got %h/%h want 00000011/00000022", hi, lo); end
  endtask

  task automatic test_op_none;
    write_reg(4'd0, 32'h99);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL none_busy got %0b want 0", busy); end
    write_reg(4'd11, 32'h99);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op11_busy got %0b want 0", busy); end
    n_tests++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL none_hilo got %h/%h want 00000011/00000022", hi, lo); end
  endtask

  task automatic test_async_reset;
    int bc, dc;
    write_reg(4'd5, 32'h33);
    write_reg(4'd6, 32'h44);
    @(negedge clk);
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_busy_done got %0b%0b want 00", busy, done); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL areset_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    bc = 0;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    n_tests++; if (bc != 0 || dc != 0) begin n_fail++; $display("FAIL areset_after_busy_done got %0d/%0d want 0/0", bc, dc); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL areset_after_hilo got %h/%h want 0/0", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int bc, dc;
    run_op(4'd2, 32'd6, 32'd7, bc, dc);
    n_tests++; if (hi !== 32'h0 || lo !== 32'd42) begin n_fail++; $display("FAIL b2b_multu got %h/%h want 0/0000002a", hi, lo); end
    run_op(4'd1, 32'h80000000, 32'h80000000, bc, dc);
    n_tests++; if (hi !== 32'h40000000 || lo !== 32'h0) begin n_fail++; $display("FAIL b2b_mult got %h/%h want 40000000/0", hi, lo); end
    n_tests++; if (bc != 5 || dc != 1) begin n_fail++; $display("FAIL b2b_cycles got %0d/%0d want 5/1", bc, dc); end
  endtask

  task automatic test_madd;
    int bc, dc;
`ifdef MDU_MADD_EN
    write_reg(4'd5, 32'h0);
    write_reg(4'd6, 32'd10);
    run_op(4'd7, 32'd3, 32'd4, bc, dc);
    n_tests++; if (bc != 5 || dc != 1) begin n_fail++; $display("FAIL madd_cycles got %0d/%0d want 5/1", bc, dc); end
    n_tests++; if (hi !== 32'h0 || lo !== 32'd22) begin n_fail++; $display("FAIL madd_hilo got %h/%h want 0/00000016", hi, lo); end
    run_op(4'd10, 32'd1, 32'd23, bc, dc);
    n_tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL msubu_hilo got %h/%h want ffffffff/ffffffff", hi, lo); end
`else
    write_reg(4'd5, 32'h5);
    write_reg(4'd6, 32'hA);
    run_op(4'd7, 32'd3, 32'd4, bc, dc);
    n_tests++; if (bc != 0 || dc != 0) begin n_fail++; $display("FAIL madd_off_cycles got %0d/%0d want 0/0", bc, dc); end
    n_tests++; if (hi !== 32'h5 || lo !== 32'hA) begin n_fail++; $display("FAIL madd_off_hilo got %h/%h want 5/a", hi, lo); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_op_none();
    test_async_reset();
    test_back_to_back();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
